// File: rtl/counter_driver.sv
`default_nettype none
// ============================================================================
// counter_driver: walks an external up/down counter one step at a time to a
// requested target, aborting on overflow or an unresponsive counter.
// Revision 1.0
// ============================================================================
module counter_driver #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_target,
  output logic       req_ready,
  input  logic [3:0] count,
  input  logic       overflow,
  output logic       act,
  output logic       up_down,
  output logic       done,
  output logic       err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          err_nxt;
  logic [3:0]    target;
  logic [3:0]    snap;
  logic [TW-1:0] tcnt;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = (count == req_target) ? S_DONE : S_STEP;
        end
      end
      S_STEP: state_nxt = S_WAIT;
      S_WAIT: begin
        // Priority: overflow, arrival, progress, then timeout.
        if (overflow) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end else if (count == target) begin
          state_nxt = S_DONE;
        end else if (count != snap) begin
          state_nxt = S_STEP;
        end else if (tcnt == TMAX) begin
          state_nxt = S_DONE;
          err_nxt   = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      err     <= 1'b0;
      target  <= 4'd0;
      snap    <= 4'd0;
      tcnt    <= '0;
      up_down <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (state == S_IDLE && req_valid) begin
        target  <= req_target;
        up_down <= (req_target > count);
      end
      // snap holds the pre-step count so WAIT can detect the counter moving.
      if (state == S_STEP) begin
        snap <= count;
        tcnt <= '0;
      end else if (state == S_WAIT && tcnt != TMAX) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign act       = (state == S_STEP);
  assign req_ready = (state == S_IDLE);
  assign done      = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_counter_driver.sv
`default_nettype none
// ============================================================================
// tb_counter_driver: randomized bench with a transaction-level timeline model
// Revision 1.0
// ============================================================================
module tb_counter_driver;

  localparam int TIMEOUT  = 4;
  localparam int M_NORMAL = 0;
  localparam int M_FROZEN = 1;
  localparam int M_OVF    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_target = 4'd0;
  logic [3:0] count = 4'd0;
  logic       overflow = 1'b0;
  logic       req_ready;
  logic       act;
  logic       up_down;
  logic       done;
  logic       err;

  counter_driver #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .count      (count),
    .overflow   (overflow),
    .act        (act),
    .up_down    (up_down),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic act;
    logic done;
    logic err;
    logic ready;
    logic ud;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   chk_en = 1'b0;
  int   mode   = M_NORMAL;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic void push_ent(input logic a, input logic d, input logic e, input logic ud);
    exp_t x;
    x.act   = a;
    x.done  = d;
    x.err   = e;
    x.ready = 1'b0;
    x.ud    = ud;
    exp_q.push_back(x);
  endfunction

  // Expected per-cycle outputs after acceptance, derived from the request alone.
  function automatic int plan(input int c, input int t, input int m);
    int   d;
    int   nsteps;
    int   nwait;
    logic up;
    logic fail;
    d  = (c > t) ? c - t : t - c;
    up = (t > c);
    if (d == 0) begin
      push_ent(1'b0, 1'b1, 1'b0, 1'b0);
      return 1;
    end
    nsteps = (m == M_NORMAL) ? d : 1;
    nwait  = (m == M_FROZEN) ? TIMEOUT + 1 : 1;
    fail   = (m != M_NORMAL);
    for (int i = 0; i < nsteps; i++) begin
      push_ent(1'b1, 1'b0, 1'b0, up);
      for (int j = 0; j < nwait; j++) push_ent(1'b0, 1'b0, 1'b0, up);
    end
    push_ent(1'b0, 1'b1, fail, up);
    return nsteps * (1 + nwait) + 1;
  endfunction

  task automatic compare_loop();
    exp_t cur;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
        end else begin
          cur.act = 1'b0; cur.done = 1'b0; cur.err = 1'b0; cur.ready = 1'b1; cur.ud = 1'b0;
        end
        n_cmp++;
        if (act !== cur.act || done !== cur.done || req_ready !== cur.ready ||
            (cur.done && err !== cur.err) || (cur.act && up_down !== cur.ud)) begin
          n_bad++;
          $display("FAIL cycle t=%0t: act=%b done=%b err=%b ready=%b up_down=%b, required act=%b done=%b err=%b ready=%b up_down=%b",
                   $time, act, done, err, req_ready, up_down,
                   cur.act, cur.done, cur.err, cur.ready, cur.ud);
        end
      end
    end
  endtask

  // One clock cycle; the emulated counter responds just after the step edge.
  task automatic tick();
    logic a;
    logic ud;
    a  = act;
    ud = up_down;
    @(posedge clk);
    #1;
    if (a && mode != M_FROZEN) count = ud ? count + 4'd1 : count - 4'd1;
    if (a && mode == M_OVF) overflow = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic run_req(input int c, input int t, input int m,
                         output int acts, output int done_cyc, output int done_err);
    int len;
    count      = 4'(c);
    overflow   = 1'b0;
    mode       = m;
    req_valid  = 1'b1;
    req_target = 4'(t);
    len        = plan(c, t, m);
    acts       = 0;
    done_cyc   = -1;
    done_err   = -1;
    for (int k = 1; k <= len + 1; k++) begin
      tick();
      if (act) acts++;
      if (done && done_cyc < 0) begin
        done_cyc = k;
        done_err = int'(err);
      end
      if (k < len) begin
        req_valid  = 1'($urandom_range(0, 1));
        req_target = 4'($urandom_range(0, 15));
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int a;
    int dc;
    int de;
    int c;
    int t;
    int r;
    int m;
    fork
      compare_loop();
    join_none

    #2 reset = 1'b0;
    #1;
    check("rst_act", int'(act), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_up_down", int'(up_down), 0);
    repeat (2) @(negedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    run_req(3, 6, M_NORMAL, a, dc, de);
    check("up3_acts", a, 3);
    check("up3_done_cycle", dc, 7);
    check("up3_err", de, 0);

    run_req(9, 2, M_NORMAL, a, dc, de);
    check("down7_acts", a, 7);
    check("down7_done_cycle", dc, 15);
    check("down7_err", de, 0);

    run_req(5, 5, M_NORMAL, a, dc, de);
    check("equal_acts", a, 0);
    check("equal_done_cycle", dc, 1);
    check("equal_err", de, 0);

    run_req(4, 8, M_FROZEN, a, dc, de);
    check("frozen_acts", a, 1);
    check("frozen_done_cycle", dc, 7);
    check("frozen_err", de, 1);

    run_req(14, 15, M_OVF, a, dc, de);
    check("ovf_acts", a, 1);
    check("ovf_done_cycle", dc, 3);
    check("ovf_err", de, 1);

    // Abort a 0->10 move with an asynchronous reset while in WAIT.
    count      = 4'd0;
    overflow   = 1'b0;
    mode       = M_NORMAL;
    req_valid  = 1'b1;
    req_target = 4'd10;
    void'(plan(0, 10, M_NORMAL));
    tick();
    req_valid = 1'b0;
    tick();
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    check("abort_act", int'(act), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_ready", int'(req_ready), 1);
    check("abort_up_down", int'(up_down), 0);
    @(posedge clk);
    #1;
    check("abort_done_held", int'(done), 0);
    @(negedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    run_req(2, 5, M_NORMAL, a, dc, de);
    check("post_reset_acts", a, 3);
    check("post_reset_done_cycle", dc, 7);

    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 15);
      t = $urandom_range(0, 15);
      r = $urandom_range(0, 9);
      m = (r < 7) ? M_NORMAL : ((r < 9) ? M_FROZEN : M_OVF);
      run_req(c, t, m, a, dc, de);
      check("rand_done_seen", (dc > 0) ? 1 : 0, 1);
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
